apb_bridge_master: RTL and testbench
====================================

# apb_bridge_master

Parametrised successor to the core's fixed single-peripheral transfer logic. Sits between the MIPS core's load/store path and an APB-style peripheral bus. Decodes a contiguous peripheral window into `NUM_SLAVES` select lines, runs the SETUP/ACCESS handshake, and stalls the core until completion. Returns read data and a per-transfer error flag: decode miss, slave error, or optional timeout.

## Interface
- `DATA_W`, default 32: data width of the core and APB data buses.
- `ADDR_W`, default 32: address width.
- `PERIPH_BASE`, default 128: first byte address of the peripheral window.
- `SLAVE_SPAN`, default 256: bytes per slave, power of 2.
- `NUM_SLAVES`, default 3: number of PSEL lines, 1..16.
- `TIMEOUT_CYCLES`, default 64: ACCESS cycles before abort, used only with `APB_BRIDGE_TIMEOUT_EN`.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: synchronous, active-high.
- `req_valid` in 1: core load/store in flight.
- `req_write` in 1: 1 = store (sw), 0 = load (lw).
- `req_addr` in ADDR_W: byte address from the ALU.
- `req_wdata` in DATA_W: store data.
- `stall` out 1: freeze the PC and register-file write.
- `done` out 1: one-cycle completion pulse.
- `rsp_rdata` out DATA_W: captured read data, valid with `done`.
- `rsp_err` out 1: error flag, valid with `done`.
- `PSEL` out NUM_SLAVES: one-hot slave select.
- `PENABLE` out 1: APB access phase.
- `PWRITE` out 1: APB direction.
- `PADDR` out ADDR_W: word-aligned address, `{req_addr[ADDR_W-1:2],2'b00}`.
- `PWDATA` out DATA_W: write data.
- `PRDATA` in NUM_SLAVES*DATA_W: flattened read data; slave i occupies bits [i*DATA_W +: DATA_W].
- `PREADY` in NUM_SLAVES: per-slave ready.
- `PSLVERR` in NUM_SLAVES: per-slave error.

## Operation
- In-window: `PERIPH_BASE <= req_addr < PERIPH_BASE + NUM_SLAVES*SLAVE_SPAN`. All other addresses are ignored; stall=0 and no bus activity.
- Slave index: `(req_addr - PERIPH_BASE) >> log2(SLAVE_SPAN)`.
- Unmapped case: an address at or above the window end but below `PERIPH_BASE + 16*SLAVE_SPAN` goes straight to DONE with rsp_err=1 and no PSEL.
- FSM states: IDLE, SETUP, ACCESS, DONE.
  - IDLE: an in-window `req_valid` latches addr/wdata/write/index and moves to SETUP.
  - SETUP: PSEL[idx]=1, PENABLE=0. Always moves to ACCESS.
  - ACCESS: PSEL[idx]=1, PENABLE=1. On `PREADY[idx]`, capture `PRDATA[idx]` (reads only; writes load 0) and `PSLVERR[idx]`, then move to DONE.
  - DONE: done=1 for exactly one cycle, PSEL=0, PENABLE=0, then return to IDLE. `req_valid` is not sampled in DONE.
- `stall = req_valid && in_window && state != DONE`. The core advances on the DONE edge.
- `PADDR`, `PWRITE` and `PWDATA` stay stable from SETUP through the last ACCESS cycle. They come from latched values, not live core inputs.
- `rsp_rdata` and `rsp_err` hold their values until the next capture.
- Back-to-back transfers: the next in-window request is accepted in the IDLE cycle after DONE. Minimum period is 4 cycles per transfer.
- Reset values: state=IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0; done=0, rsp_rdata=0, rsp_err=0; timeout counter=0.
- Reset mid-transfer: the next edge forces IDLE with all outputs at reset values. No done pulse is issued.

## Timing
- Request is sampled at edge 0. SETUP runs in cycle 1 and ACCESS in cycle 2.
- With PREADY already high in cycle 2, DONE is in cycle 3: a 3-cycle stall in total.
- Each low-PREADY cycle adds one cycle.
- Unmapped access: DONE in the cycle after acceptance, so 1 stall cycle.
- `done`, `rsp_*`, `PSEL`, `PENABLE` and `PADDR` are all registered. `stall` is combinational from `req_valid`/`req_addr` and state.

## Configuration
- `APB_BRIDGE_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter clears on entering ACCESS and increments each ACCESS cycle without PREADY.
  - When it reaches `TIMEOUT_CYCLES`, the bridge goes to DONE with rsp_err=1 and rsp_rdata=0. PSEL/PENABLE deassert on that edge.
  - PREADY arriving in the same cycle as the timeout wins: the transfer completes normally.
- Undefined: no counter, and ACCESS waits indefinitely.

## Structure
- Package `apb_bridge_pkg` holds:
  - the state enum (IDLE/SETUP/ACCESS/DONE, 2-bit);
  - the `MAX_SLAVES=16` constant;
  - the `clog2` helper for the index width.
- One sub-module, `apb_addr_decode`: combinational. Takes addr; outputs in_window, unmapped, and a one-hot select plus index.

## Test plan
- Read from slave 1: addr 0x184, PREADY[1]=1 immediately, PRDATA[1]=0xDEADBEEF. Required: PSEL=3'b010 in cycles 1–2, PENABLE only in cycle 2, done in cycle 3 with rsp_rdata=0xDEADBEEF, rsp_err=0, and stall high for cycles 0–2.
- Write with wait states: addr 0x280 (slave 2), wdata 0x12345678, PREADY[2] low for 3 ACCESS cycles. Required: PWRITE=1, PWDATA and PADDR stable for 4 ACCESS cycles, done in cycle 6.
- Out-of-window: addr 0x40 and addr 0x400 (the latter with NUM_SLAVES=3 and an in-range index). Required for 0x40: no PSEL, stall=0. Required for 0x400: no PSEL, done after 1 cycle with rsp_err=1.
- Slave error: PSLVERR[0]=1 together with PREADY[0] on addr 0x80. Required: done with rsp_err=1.
- Timeout (macro defined, TIMEOUT_CYCLES=8): PREADY held low. Required: done with rsp_err=1 and rsp_rdata=0 after 8 ACCESS cycles, then PSEL=0. Without the macro, the bench confirms no done after 100 cycles.
- RESET asserted during ACCESS. Required: next edge gives state IDLE and all outputs 0, no done. A fresh request then completes normally in 3 cycles.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// Shared types and helpers for the APB bridge master.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StDone
    } state_e;

    localparam int unsigned MAX_SLAVES = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    localparam int unsigned IDX_W = clog2(MAX_SLAVES);

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational decode of a byte address into the bridge's slave window.
module apb_addr_decode
    import apb_bridge_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] PERIPH_BASE = ADDR_W'(128),
    parameter int unsigned       SLAVE_SPAN  = 256,
    parameter int unsigned       NUM_SLAVES  = 3
) (
    input  logic [ADDR_W-1:0]     addr_i,
    output logic                  in_window_o,
    output logic                  unmapped_o,
    output logic [NUM_SLAVES-1:0] sel_o,
    output logic [IDX_W-1:0]      idx_o
);

    localparam int unsigned SPAN_LOG = clog2(SLAVE_SPAN);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] slot;
    logic              above_base;

    always_comb begin
        offset      = addr_i - PERIPH_BASE;
        slot        = offset >> SPAN_LOG;
        above_base  = (addr_i >= PERIPH_BASE);
        in_window_o = above_base && (slot < ADDR_W'(NUM_SLAVES));
        // Slots past the populated slaves but inside the 16-slot map answer with an error.
        unmapped_o  = above_base && !in_window_o && (slot < ADDR_W'(MAX_SLAVES));
        idx_o       = slot[IDX_W-1:0];
        sel_o       = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            sel_o[i] = in_window_o && (slot == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/apb_bridge_master.sv
// Core-to-APB bridge: window decode, SETUP/ACCESS handshake, core stall and response capture.
// Optional ACCESS timeout is enabled by defining APB_BRIDGE_TIMEOUT_EN.
module apb_bridge_master
    import apb_bridge_pkg::*;
#(
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] PERIPH_BASE    = ADDR_W'(128),
    parameter int unsigned       SLAVE_SPAN     = 256,
    parameter int unsigned       NUM_SLAVES     = 3,
    parameter int unsigned       TIMEOUT_CYCLES = 64
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         req_valid,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         stall,
    output logic                         done,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [ADDR_W-1:0]            PADDR,
    output logic [DATA_W-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    state_e                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]       paddr_q, paddr_d;
    logic [DATA_W-1:0]       pwdata_q, pwdata_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    done_q, done_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    dec_in_window;
    logic                    dec_unmapped;
    logic [NUM_SLAVES-1:0]   dec_sel;
    logic [IDX_W-1:0]        dec_idx;

    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_W-1:0]       sel_rdata;

    apb_addr_decode #(
        .ADDR_W      (ADDR_W),
        .PERIPH_BASE (PERIPH_BASE),
        .SLAVE_SPAN  (SLAVE_SPAN),
        .NUM_SLAVES  (NUM_SLAVES)
    ) u_decode (
        .addr_i      (req_addr),
        .in_window_o (dec_in_window),
        .unmapped_o  (dec_unmapped),
        .sel_o       (dec_sel),
        .idx_o       (dec_idx)
    );

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = (clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timed_out;

    assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        rdata_d   = rdata_q;
        err_d     = err_q;
`ifdef APB_BRIDGE_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid && dec_in_window) begin
                    psel_d   = dec_sel;
                    pwrite_d = req_write;
                    paddr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                    pwdata_d = req_wdata;
                    idx_d    = dec_idx;
                    state_d  = StSetup;
                end else if (req_valid && dec_unmapped) begin
                    done_d  = 1'b1;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                state_d   = StAccess;
`ifdef APB_BRIDGE_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            StAccess: begin
                if (sel_ready) begin
                    rdata_d   = pwrite_q ? '0 : sel_rdata;
                    err_d     = sel_err;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = StDone;
                end
`ifdef APB_BRIDGE_TIMEOUT_EN
                else if (timed_out) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StIdle;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Unmapped addresses stall for their single decode cycle, like mapped ones.
    assign stall     = req_valid && (dec_in_window || dec_unmapped) && (state_q != StDone);
    assign done      = done_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_bridge_master.sv
// Directed self-checking bench for apb_bridge_master (3 slaves, base 0x80, span 0x100).
module tb_apb_bridge_master;

    localparam int unsigned NS = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             req_valid;
    logic             req_write;
    logic [AW-1:0]    req_addr;
    logic [DW-1:0]    req_wdata;
    logic             stall;
    logic             done;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic [NS-1:0]    PSEL;
    logic             PENABLE;
    logic             PWRITE;
    logic [AW-1:0]    PADDR;
    logic [DW-1:0]    PWDATA;
    logic [NS*DW-1:0] PRDATA;
    logic [NS-1:0]    PREADY;
    logic [NS-1:0]    PSLVERR;

    int n_pass  = 0;
    int n_total = 0;

    apb_bridge_master #(
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .PERIPH_BASE    (32'h80),
        .SLAVE_SPAN     (256),
        .NUM_SLAVES     (NS),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .done      (done),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " PSEL"}, 64'(PSEL), 64'h0);
        chk({tag, " PENABLE"}, 64'(PENABLE), 64'h0);
        chk({tag, " PWRITE"}, 64'(PWRITE), 64'h0);
        chk({tag, " PADDR"}, 64'(PADDR), 64'h0);
        chk({tag, " PWDATA"}, 64'(PWDATA), 64'h0);
        chk({tag, " done"}, 64'(done), 64'h0);
        chk({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'h0);
        chk({tag, " rsp_err"}, 64'(rsp_err), 64'h0);
    endtask

    initial begin
        int saw_done;
        RESET     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        PRDATA    = {32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
        PREADY    = '0;
        PSLVERR   = '0;
        cyc();
        cyc();
        RESET = 1'b0;
        settle();
        check_reset_outputs("reset");
        chk("reset stall", 64'(stall), 64'h0);

        // Read slave 1, zero wait states.
        cyc();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h184;
        PREADY    = 3'b010;
        settle();
        chk("rd c0 stall", 64'(stall), 64'h1);
        chk("rd c0 PSEL", 64'(PSEL), 64'h0);
        cyc();
        chk("rd c1 PSEL", 64'(PSEL), 64'h2);
        chk("rd c1 PENABLE", 64'(PENABLE), 64'h0);
        chk("rd c1 PADDR", 64'(PADDR), 64'h184);
        chk("rd c1 stall", 64'(stall), 64'h1);
        cyc();
        chk("rd c2 PSEL", 64'(PSEL), 64'h2);
        chk("rd c2 PENABLE", 64'(PENABLE), 64'h1);
        chk("rd c2 stall", 64'(stall), 64'h1);
        chk("rd c2 done", 64'(done), 64'h0);
        cyc();
        chk("rd c3 done", 64'(done), 64'h1);
        chk("rd c3 rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
        chk("rd c3 err", 64'(rsp_err), 64'h0);
        chk("rd c3 PSEL", 64'(PSEL), 64'h0);
        chk("rd c3 PENABLE", 64'(PENABLE), 64'h0);
        chk("rd c3 stall", 64'(stall), 64'h0);
        req_valid = 1'b0;
        PREADY    = '0;
        cyc();
        chk("rd c4 done", 64'(done), 64'h0);
        chk("rd c4 rdata hold", 64'(rsp_rdata), 64'hDEAD_BEEF);

        // Write slave 2 with three wait states; live wdata changes must not leak.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h280;
        req_wdata = 32'h1234_5678;
        settle();
        chk("wr c0 stall", 64'(stall), 64'h1);
        cyc();
        req_wdata = 32'hFFFF_FFFF;
        chk("wr c1 PSEL", 64'(PSEL), 64'h4);
        chk("wr c1 PWRITE", 64'(PWRITE), 64'h1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k == 3) PREADY = 3'b100;
            chk("wr access PENABLE", 64'(PENABLE), 64'h1);
            chk("wr access PADDR", 64'(PADDR), 64'h280);
            chk("wr access PWDATA", 64'(PWDATA), 64'h1234_5678);
            chk("wr access PWRITE", 64'(PWRITE), 64'h1);
            chk("wr access done", 64'(done), 64'h0);
        end
        cyc();
        chk("wr c6 done", 64'(done), 64'h1);
        chk("wr c6 rdata", 64'(rsp_rdata), 64'h0);
        chk("wr c6 err", 64'(rsp_err), 64'h0);
        req_valid = 1'b0;
        req_write = 1'b0;
        PREADY    = '0;
        cyc();

        // Below the window: ignored entirely.
        req_valid = 1'b1;
        req_addr  = 32'h40;
        settle();
        chk("low stall", 64'(stall), 64'h0);
        cyc();
        chk("low PSEL", 64'(PSEL), 64'h0);
        chk("low done", 64'(done), 64'h0);
        cyc();
        chk("low done2", 64'(done), 64'h0);

        // Unmapped slot 3: one-cycle error completion.
        req_addr = 32'h400;
        settle();
        chk("unm c0 stall", 64'(stall), 64'h1);
        cyc();
        chk("unm c1 done", 64'(done), 64'h1);
        chk("unm c1 err", 64'(rsp_err), 64'h1);
        chk("unm c1 PSEL", 64'(PSEL), 64'h0);
        chk("unm c1 stall", 64'(stall), 64'h0);
        req_valid = 1'b0;
        cyc();
        chk("unm c2 done", 64'(done), 64'h0);

        // Slave error on slave 0.
        req_valid = 1'b1;
        req_addr  = 32'h80;
        PREADY    = 3'b001;
        PSLVERR   = 3'b001;
        cyc();
        chk("serr c1 PSEL", 64'(PSEL), 64'h1);
        cyc();
        cyc();
        chk("serr c3 done", 64'(done), 64'h1);
        chk("serr c3 err", 64'(rsp_err), 64'h1);
        chk("serr c3 rdata", 64'(rsp_rdata), 64'h1111_1111);
        req_valid = 1'b0;
        PREADY    = '0;
        PSLVERR   = '0;
        cyc();

        // PREADY held low.
        req_valid = 1'b1;
        req_addr  = 32'h184;
        cyc();
`ifdef APB_BRIDGE_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("to access PENABLE", 64'(PENABLE), 64'h1);
            chk("to access done", 64'(done), 64'h0);
        end
        cyc();
        chk("to done", 64'(done), 64'h1);
        chk("to err", 64'(rsp_err), 64'h1);
        chk("to rdata", 64'(rsp_rdata), 64'h0);
        chk("to PSEL", 64'(PSEL), 64'h0);
        chk("to PENABLE", 64'(PENABLE), 64'h0);
        req_valid = 1'b0;
        cyc();
        req_valid = 1'b1;
        cyc();
        cyc();
`else
        saw_done = 0;
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (done === 1'b1) saw_done++;
        end
        chk("noto done count", 64'(saw_done), 64'h0);
        chk("noto PSEL", 64'(PSEL), 64'h2);
`endif
        // Bridge is now in ACCESS on slave 1; reset it there.
        chk("rst pre PENABLE", 64'(PENABLE), 64'h1);
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        check_reset_outputs("midreset");
        PREADY = 3'b010;
        PRDATA = {32'h2222_2222, 32'hCAFE_F00D, 32'h1111_1111};
        cyc();
        chk("fresh c1 PSEL", 64'(PSEL), 64'h2);
        chk("fresh c1 done", 64'(done), 64'h0);
        cyc();
        chk("fresh c2 PENABLE", 64'(PENABLE), 64'h1);
        cyc();
        chk("fresh c3 done", 64'(done), 64'h1);
        chk("fresh c3 rdata", 64'(rsp_rdata), 64'hCAFE_F00D);
        chk("fresh c3 err", 64'(rsp_err), 64'h0);
        req_valid = 1'b0;
        PREADY    = '0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
